id_ex_operand_stage: RTL

//  ID/EX pipeline register plus operand forwarding for the pipelined core. Captures decoded

---
 rtl/id_ex_operand_stage.sv | 122 ++++++++++++
 1 files changed

// File: rtl/id_ex_operand_stage.sv
// ID/EX pipeline register with operand forwarding.
// Captures decoded operands/control from ID and presents ALU operands in EX,
// bypassing EX/MEM and MEM/WB results to resolve read-after-write hazards.
module id_ex_operand_stage #(
    parameter int DATA_WIDTH     = 32,
    parameter int ALU_CODE_WIDTH = 4,
    parameter int REG_NUM_WIDTH  = 5
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      stall,
    input  logic                      flush,
    input  logic                      idValid,
    input  logic [DATA_WIDTH-1:0]     idRdA,
    input  logic [DATA_WIDTH-1:0]     idRdB,
    input  logic [DATA_WIDTH-1:0]     idImm,
    input  logic                      idUseImm,
    input  logic [ALU_CODE_WIDTH-1:0] idALUCode,
    input  logic [REG_NUM_WIDTH-1:0]  idRs,
    input  logic [REG_NUM_WIDTH-1:0]  idRt,
    input  logic [REG_NUM_WIDTH-1:0]  idWrNum,
    input  logic                      idWrEnable,
    input  logic                      memWrEnable,
    input  logic [REG_NUM_WIDTH-1:0]  memWrNum,
    input  logic [DATA_WIDTH-1:0]     memResult,
    input  logic                      wbWrEnable,
    input  logic [REG_NUM_WIDTH-1:0]  wbWrNum,
    input  logic [DATA_WIDTH-1:0]     wbResult,
    output logic                      exValid,
    output logic [DATA_WIDTH-1:0]     aluInA,
    output logic [DATA_WIDTH-1:0]     aluInB,
    output logic [ALU_CODE_WIDTH-1:0] exALUCode,
    output logic [DATA_WIDTH-1:0]     exStoreData,
    output logic [REG_NUM_WIDTH-1:0]  exWrNum,
    output logic                      exWrEnable
);

    // Select the newest value of a register: EX/MEM result first, then MEM/WB,
    // else the fallback. r0 is hard-wired zero and is never bypassed.
    function automatic logic [DATA_WIDTH-1:0] bypass(
        input logic [REG_NUM_WIDTH-1:0] regNum,
        input logic [DATA_WIDTH-1:0]    fallback,
        input logic                     memEn,
        input logic [REG_NUM_WIDTH-1:0] memNum,
        input logic [DATA_WIDTH-1:0]    memVal,
        input logic                     wbEn,
        input logic [REG_NUM_WIDTH-1:0] wbNum,
        input logic [DATA_WIDTH-1:0]    wbVal
    );
        logic [DATA_WIDTH-1:0] sel;
        sel = fallback;
        if (regNum != '0) begin
            if (memEn && (memNum == regNum))
                sel = memVal;
            else if (wbEn && (wbNum == regNum))
                sel = wbVal;
        end
        return sel;
    endfunction

    // EX stage registers
    logic                      vld_p1;
    logic                      wrEn_p1;
    logic [REG_NUM_WIDTH-1:0]  wrNum_p1;
    logic [ALU_CODE_WIDTH-1:0] aluCode_p1;
    logic [REG_NUM_WIDTH-1:0]  rs_p1;
    logic [REG_NUM_WIDTH-1:0]  rt_p1;
    logic [DATA_WIDTH-1:0]     rdA_p1;
    logic [DATA_WIDTH-1:0]     rdB_p1;
    logic [DATA_WIDTH-1:0]     imm_p1;
    logic                      useImm_p1;

    // Capture-time bypass covers the register-file write happening this same cycle.
    logic [DATA_WIDTH-1:0] capA;
    logic [DATA_WIDTH-1:0] capB;
    assign capA = bypass(idRs, idRdA, 1'b0, '0, '0, wbWrEnable, wbWrNum, wbResult);
    assign capB = bypass(idRt, idRdB, 1'b0, '0, '0, wbWrEnable, wbWrNum, wbResult);

    // ---- ID -> EX boundary: reset clears, flush inserts a bubble, stall holds ----
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            vld_p1     <= 1'b0;
            wrEn_p1    <= 1'b0;
            wrNum_p1   <= '0;
            aluCode_p1 <= '0;
            rs_p1      <= '0;
            rt_p1      <= '0;
            rdA_p1     <= '0;
            rdB_p1     <= '0;
            imm_p1     <= '0;
            useImm_p1  <= 1'b0;
        end else if (!stall) begin
            vld_p1     <= idValid;
            wrEn_p1    <= idWrEnable;
            wrNum_p1   <= idWrNum;
            aluCode_p1 <= idALUCode;
            rs_p1      <= idRs;
            rt_p1      <= idRt;
            rdA_p1     <= capA;
            rdB_p1     <= capB;
            imm_p1     <= idImm;
            useImm_p1  <= idUseImm;
        end
    end

    // EX forwarding on the latched source numbers; tracks mem/wb every cycle.
    logic [DATA_WIDTH-1:0] fwdA;
    logic [DATA_WIDTH-1:0] fwdB;
    assign fwdA = bypass(rs_p1, rdA_p1, memWrEnable, memWrNum, memResult,
                         wbWrEnable, wbWrNum, wbResult);
    assign fwdB = bypass(rt_p1, rdB_p1, memWrEnable, memWrNum, memResult,
                         wbWrEnable, wbWrNum, wbResult);

    assign exValid     = vld_p1;
    assign aluInA      = fwdA;
    assign aluInB      = useImm_p1 ? imm_p1 : fwdB;
    assign exStoreData = fwdB;
    assign exALUCode   = aluCode_p1;
    assign exWrNum     = wrNum_p1;
    assign exWrEnable  = wrEn_p1 & vld_p1;

endmodule
